sort_engine_axi: RTL and testbench

- Parametrised successor of the single-array insertion-sort circuit.
- Sorts `arr_size` words in place in external memory, starting at a runtime base address.
- Sort direction (ascending or descending) is selectable per run; compare is signed or unsigned by parameter.
- Aborts cleanly on a nonzero read or write response. One controller FSM drives separate AR/R/AW/W/B channels.

---
 rtl/sort_engine_axi.sv | 200 ++++++++++++++++++++
 tb/tb_sort_engine_axi.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_engine_axi.sv
// In-place insertion sort of an array in external memory over split AR/R/AW/W/B channels.
// One request is outstanding at a time. Any nonzero read or write response aborts the run.
module sort_engine_axi #(
  parameter int ADDR_WDTH  = 4,
  parameter int DATA_WDTH  = 32,
  parameter int RESP_WDTH  = 2,
  parameter bit SIGNED_CMP = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_WDTH:0]   arr_size,
  input  logic [ADDR_WDTH-1:0] base_addr,
  input  logic                 descending,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_WDTH-1:0] ar_address,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  input  logic [DATA_WDTH-1:0] r_data,
  input  logic [RESP_WDTH-1:0] r_resp,
  input  logic                 r_valid,
  output logic                 r_ready,
  output logic [ADDR_WDTH-1:0] aw_address,
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [DATA_WDTH-1:0] w_data,
  output logic                 w_valid,
  input  logic                 w_ready,
  input  logic [RESP_WDTH-1:0] b_resp,
  input  logic                 b_valid,
  output logic                 b_ready
);
  typedef enum logic [3:0] {
    IDLE, RD_KEY_AR, RD_KEY_R, RD_CMP_AR, RD_CMP_R,
    WR_SHIFT, WR_SHIFT_B, WR_KEY, WR_KEY_B, FINISH
  } state_e;

  localparam logic [ADDR_WDTH:0] IDX_ONE = {{ADDR_WDTH{1'b0}}, 1'b1};

  state_e state_q, state_d;
  logic [ADDR_WDTH:0]   n_q, i_q, p_q;
  logic [ADDR_WDTH-1:0] base_q, addr_q;
  logic [DATA_WDTH-1:0] key_q, wdata_q;
  logic desc_q, err_q, done_q, aw_done_q, w_done_q;

  logic ar_hs, aw_hs, w_hs, wr_both, r_err, b_err, gt, lt, ooo, last_i;
  logic [ADDR_WDTH:0] i_inc, i_dec, p_dec, p_dec2;

  assign ar_hs   = ar_valid & ar_ready;
  assign aw_hs   = aw_valid & aw_ready;
  assign w_hs    = w_valid & w_ready;
  assign wr_both = (aw_done_q | aw_hs) & (w_done_q | w_hs);
  assign r_err   = (r_resp != '0);
  assign b_err   = (b_resp != '0);
  assign i_inc   = i_q + IDX_ONE;
  assign i_dec   = i_q - IDX_ONE;
  assign p_dec   = p_q - IDX_ONE;
  assign p_dec2  = p_dec - IDX_ONE;
  assign last_i  = (i_inc == n_q);

  // Strict compare keeps equal keys in their original order.
  always_comb begin
    if (SIGNED_CMP) begin
      gt = $signed(r_data) > $signed(key_q);
      lt = $signed(r_data) < $signed(key_q);
    end else begin
      gt = r_data > key_q;
      lt = r_data < key_q;
    end
  end
  assign ooo = desc_q ? lt : gt;

  function automatic logic [ADDR_WDTH-1:0] phys(input logic [ADDR_WDTH:0] idx);
    return base_q + idx[ADDR_WDTH-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (start) state_d = (arr_size <= IDX_ONE) ? FINISH : RD_KEY_AR;
      RD_KEY_AR:  if (ar_hs) state_d = RD_KEY_R;
      RD_KEY_R:   if (r_valid) state_d = r_err ? FINISH : RD_CMP_AR;
      RD_CMP_AR:  if (ar_hs) state_d = RD_CMP_R;
      RD_CMP_R:
        if (r_valid) begin
          if (r_err)           state_d = FINISH;
          else if (ooo)        state_d = WR_SHIFT;
          else if (p_q != i_q) state_d = WR_KEY;
          else                 state_d = last_i ? FINISH : RD_KEY_AR;
        end
      WR_SHIFT:   if (wr_both) state_d = WR_SHIFT_B;
      WR_SHIFT_B:
        if (b_valid) begin
          if (b_err)             state_d = FINISH;
          else if (p_dec != '0)  state_d = RD_CMP_AR;
          else                   state_d = WR_KEY;
        end
      WR_KEY:     if (wr_both) state_d = WR_KEY_B;
      WR_KEY_B:   if (b_valid) state_d = (b_err || last_i) ? FINISH : RD_KEY_AR;
      FINISH:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    ar_valid = (state_q == RD_KEY_AR) || (state_q == RD_CMP_AR);
    r_ready  = (state_q == RD_KEY_R)  || (state_q == RD_CMP_R);
    aw_valid = ((state_q == WR_SHIFT) || (state_q == WR_KEY)) && !aw_done_q;
    w_valid  = ((state_q == WR_SHIFT) || (state_q == WR_KEY)) && !w_done_q;
    b_ready  = (state_q == WR_SHIFT_B) || (state_q == WR_KEY_B);
  end

  assign done       = done_q;
  assign err        = err_q;
  assign ar_address = addr_q;
  assign aw_address = addr_q;
  assign w_data     = wdata_q;

  // addr_q is loaded on the transition into each request state so it is stable while valid is up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q <= '0; i_q <= '0; p_q <= '0; base_q <= '0; addr_q <= '0;
      key_q <= '0; wdata_q <= '0; desc_q <= 1'b0; err_q <= 1'b0;
      done_q <= 1'b0; aw_done_q <= 1'b0; w_done_q <= 1'b0;
    end else begin
      done_q <= (state_q == FINISH);
      case (state_q)
        IDLE:
          if (start) begin
            n_q    <= arr_size;
            base_q <= base_addr;
            desc_q <= descending;
            err_q  <= 1'b0;
            i_q    <= IDX_ONE;
            addr_q <= base_addr + ADDR_WDTH'(1);
          end
        RD_KEY_R:
          if (r_valid) begin
            if (r_err) err_q <= 1'b1;
            else begin
              key_q  <= r_data;
              p_q    <= i_q;
              addr_q <= phys(i_dec);
            end
          end
        RD_CMP_R:
          if (r_valid) begin
            if (r_err) err_q <= 1'b1;
            else if (ooo) begin
              addr_q  <= phys(p_q);
              wdata_q <= r_data;
            end else if (p_q != i_q) begin
              addr_q  <= phys(p_q);
              wdata_q <= key_q;
            end else begin
              i_q    <= i_inc;
              addr_q <= phys(i_inc);
            end
          end
        WR_SHIFT, WR_KEY:
          if (wr_both) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            aw_done_q <= aw_done_q | aw_hs;
            w_done_q  <= w_done_q | w_hs;
          end
        WR_SHIFT_B:
          if (b_valid) begin
            if (b_err) err_q <= 1'b1;
            else begin
              p_q <= p_dec;
              if (p_dec != '0) addr_q <= phys(p_dec2);
              else begin
                addr_q  <= base_q;
                wdata_q <= key_q;
              end
            end
          end
        WR_KEY_B:
          if (b_valid) begin
            if (b_err) err_q <= 1'b1;
            else begin
              i_q    <= i_inc;
              addr_q <= phys(i_inc);
            end
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_engine_axi.sv
// Directed bench for sort_engine_axi: memory/slave model, vector table, and corner-case sequences.
module tb_sort_engine_axi;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RW = 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, descending = 1'b0;
  logic [AW:0]   arr_size = '0;
  logic [AW-1:0] base_addr = '0;
  logic busy, done, err;
  logic [AW-1:0] ar_address, aw_address;
  logic ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic ar_ready = 1'b0, r_valid = 1'b0, aw_ready = 1'b0, w_ready = 1'b0, b_valid = 1'b0;
  logic [DW-1:0] r_data = '0, w_data;
  logic [RW-1:0] r_resp = '0, b_resp = '0;

  always #5 clk = ~clk;

  sort_engine_axi #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW), .SIGNED_CMP(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .arr_size(arr_size), .base_addr(base_addr),
    .descending(descending), .busy(busy), .done(done), .err(err),
    .ar_address(ar_address), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .aw_address(aw_address), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready)
  );

  logic [DW-1:0] mem [16];
  int tests = 0, fails = 0;
  int maxd = 0, err_wr = -1;
  int ar_cnt = 0, aw_cnt = 0, wr_cnt = 0, done_cnt = 0, ovl_cnt = 0;
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  bit ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, b_pend, aw_got, w_got;
  logic [AW-1:0] ar_lat, aw_lat, raddr, waddr;
  logic [DW-1:0] w_lat, wdat;

  typedef struct {
    string name; int base; int size; bit desc;
    logic [5:0][31:0] in_v; logic [5:0][31:0] ex_v; int n_ar; int n_aw;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [5:0][31:0] pk(input logic [31:0] a, b, c, d, e, f);
    logic [5:0][31:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f;
    return r;
  endfunction

  function automatic vec_t mk(input string nm, input int base, size, input bit desc,
                              input logic [5:0][31:0] iv, ev, input int nar, naw);
    vec_t v;
    v.name = nm; v.base = base; v.size = size; v.desc = desc;
    v.in_v = iv; v.ex_v = ev; v.n_ar = nar; v.n_aw = naw;
    return v;
  endfunction

  function automatic int dly();
    return int'($urandom_range(0, maxd));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory slave, advanced once per falling edge; handshakes seen here complete at the next rising edge.
  task automatic slave_step();
    if (rst) begin
      ar_ready = 0; r_valid = 0; aw_ready = 0; w_ready = 0; b_valid = 0;
      r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
      return;
    end
    if (done) done_cnt++;
    if ((ar_valid || r_ready) && (aw_valid || w_valid || b_ready)) ovl_cnt++;
    if (ar_hs) begin ar_ready = 0; ar_cnt++; raddr = ar_lat; r_pend = 1; r_dly = dly(); ar_dly = dly(); end
    if (r_hs) r_valid = 0;
    if (aw_hs) begin aw_ready = 0; aw_cnt++; waddr = aw_lat; aw_got = 1; aw_dly = dly(); end
    if (w_hs) begin w_ready = 0; wdat = w_lat; w_got = 1; w_dly = dly(); end
    if (b_hs) b_valid = 0;
    if (aw_got && w_got) begin
      aw_got = 0; w_got = 0;
      if (wr_cnt == err_wr) b_resp = 2'd2;
      else begin b_resp = 2'd0; mem[waddr] = wdat; end
      wr_cnt++; b_pend = 1; b_dly = dly();
    end
    if (ar_valid) begin if (!ar_ready) begin if (ar_dly == 0) ar_ready = 1; else ar_dly--; end end
    else ar_ready = (maxd > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (aw_valid) begin if (!aw_ready) begin if (aw_dly == 0) aw_ready = 1; else aw_dly--; end end
    else aw_ready = (maxd > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (w_valid) begin if (!w_ready) begin if (w_dly == 0) w_ready = 1; else w_dly--; end end
    else w_ready = (maxd > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (r_pend && !r_valid) begin
      if (r_dly == 0) begin r_valid = 1; r_data = mem[raddr]; r_resp = '0; r_pend = 0; end
      else r_dly--;
    end
    if (b_pend && !b_valid) begin
      if (b_dly == 0) begin b_valid = 1; b_pend = 0; end
      else b_dly--;
    end
    ar_hs = ar_valid && ar_ready; ar_lat = ar_address;
    aw_hs = aw_valid && aw_ready; aw_lat = aw_address;
    w_hs  = w_valid && w_ready;   w_lat  = w_data;
    r_hs  = r_valid && r_ready;
    b_hs  = b_valid && b_ready;
  endtask

  task automatic tick();
    @(negedge clk);
    slave_step();
  endtask

  task automatic init_mem(input vec_t v);
    for (int k = 0; k < 16; k++) mem[k] = 32'hA5A5_0000 | k;
    for (int j = 0; j < v.size; j++) mem[(v.base + j) % 16] = v.in_v[j];
  endtask

  task automatic check_mem(input string nm, input vec_t v);
    logic [DW-1:0] img [16];
    int bad = 0;
    for (int k = 0; k < 16; k++) img[k] = 32'hA5A5_0000 | k;
    for (int j = 0; j < v.size; j++) img[(v.base + j) % 16] = v.ex_v[j];
    for (int k = 0; k < 16; k++) if (mem[k] !== img[k]) bad++;
    chk(nm, bad, 0);
  endtask

  // Inputs are scrambled right after the start cycle; the run must use the latched copies.
  task automatic run(input vec_t v, output bit busy1, output bit err1, output bit got_done);
    base_addr = AW'(v.base); arr_size = (AW+1)'(v.size); descending = v.desc; start = 1;
    tick();
    start = 0; base_addr = AW'(7); arr_size = (AW+1)'(3); descending = !v.desc;
    busy1 = busy; err1 = err; got_done = 0;
    for (int c = 0; c < 2000 && !got_done; c++) begin
      if (done) got_done = 1;
      else tick();
    end
    tick();
  endtask

  initial begin
    bit b1, e1, gd, found;
    int a0, w0, d0;
    vecs[0] = mk("asc5", 0, 5, 0, pk(5, 3, 4, 1, 2, 0), pk(1, 2, 3, 4, 5, 0), 14, 12);
    vecs[1] = mk("desc_wrap", 14, 4, 1, pk(32'hFFFF_FFFF, 7, 32'hFFFF_FFF8, 3, 0, 0),
                 pk(7, 3, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 0, 0), 8, 5);
    vecs[2] = mk("sorted", 3, 4, 0, pk(1, 2, 3, 4, 0, 0), pk(1, 2, 3, 4, 0, 0), 6, 0);
    vecs[3] = mk("stable", 9, 3, 0, pk(2, 1, 2, 0, 0, 0), pk(1, 2, 2, 0, 0, 0), 4, 2);
    vecs[4] = mk("signed", 5, 3, 0, pk(1, 32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 0),
                 pk(32'h8000_0000, 1, 32'h7FFF_FFFF, 0, 0, 0), 4, 2);
    vecs[5] = mk("size1", 2, 1, 0, pk(9, 0, 0, 0, 0, 0), pk(9, 0, 0, 0, 0, 0), 0, 0);

    repeat (3) tick();
    chk("rst_ctrl", {busy, done, err}, 0);
    chk("rst_chan", {ar_valid, r_ready, aw_valid, w_valid, b_ready}, 0);
    chk("rst_addr", {ar_address, aw_address, w_data}, 0);
    rst = 0;
    repeat (5) tick();
    chk("idle_no_traffic", ar_cnt + aw_cnt, 0);

    maxd = 2;
    for (int t = 0; t < 6; t++) begin
      init_mem(vecs[t]);
      a0 = ar_cnt; w0 = aw_cnt; d0 = done_cnt;
      run(vecs[t], b1, e1, gd);
      chk($sformatf("%s_done", vecs[t].name), gd, 1);
      chk($sformatf("%s_busy", vecs[t].name), b1, 1);
      check_mem($sformatf("%s_mem", vecs[t].name), vecs[t]);
      chk($sformatf("%s_ar", vecs[t].name), ar_cnt - a0, vecs[t].n_ar);
      chk($sformatf("%s_aw", vecs[t].name), aw_cnt - w0, vecs[t].n_aw);
      chk($sformatf("%s_pulses", vecs[t].name), done_cnt - d0, 1);
      chk($sformatf("%s_err", vecs[t].name), err, 0);
    end

    // Degenerate sizes: one busy cycle, done one cycle later, no bus activity.
    for (int sz = 0; sz < 2; sz++) begin
      a0 = ar_cnt; w0 = aw_cnt;
      base_addr = '0; arr_size = (AW+1)'(sz); start = 1;
      tick(); start = 0;
      chk($sformatf("sz%0d_c1", sz), {busy, done}, 2'b10);
      tick();
      chk($sformatf("sz%0d_c2", sz), {busy, done}, 2'b01);
      tick();
      chk($sformatf("sz%0d_c3", sz), {busy, done}, 2'b00);
      chk($sformatf("sz%0d_traffic", sz), (ar_cnt - a0) + (aw_cnt - w0), 0);
    end

    // Second write answered with an error response under heavy backpressure.
    maxd = 5;
    init_mem(vecs[0]);
    err_wr = wr_cnt + 1;
    a0 = ar_cnt; w0 = aw_cnt; d0 = done_cnt;
    run(vecs[0], b1, e1, gd);
    chk("abort_done", gd, 1);
    chk("abort_err", err, 1);
    chk("abort_pulses", done_cnt - d0, 1);
    chk("abort_ar", ar_cnt - a0, 2);
    chk("abort_aw", aw_cnt - w0, 2);
    repeat (8) tick();
    chk("abort_quiet", (ar_cnt - a0) + (aw_cnt - w0), 4);
    err_wr = -1;
    init_mem(vecs[2]);
    run(vecs[2], b1, e1, gd);
    chk("err_clear_on_start", e1, 0);
    chk("after_abort_done", gd, 1);
    check_mem("after_abort_mem", vecs[2]);
    chk("after_abort_err", err, 0);

    // Reset in the middle of a write must drop the channel outputs without waiting for a clock.
    maxd = 3;
    init_mem(vecs[0]);
    base_addr = '0; arr_size = (AW+1)'(5); descending = 0; start = 1;
    tick(); start = 0;
    found = 0;
    for (int c = 0; c < 300 && !found; c++) begin
      if (aw_valid) found = 1;
      else tick();
    end
    chk("rst_reach_write", found, 1);
    rst = 1;
    #1;
    chk("rst_async_idle", {aw_valid, w_valid, busy}, 0);
    repeat (2) tick();
    rst = 0;
    d0 = done_cnt;
    repeat (4) tick();
    chk("rst_no_done", done_cnt - d0, 0);
    init_mem(vecs[0]);
    run(vecs[0], b1, e1, gd);
    chk("post_rst_done", gd, 1);
    check_mem("post_rst_mem", vecs[0]);
    chk("post_rst_err", err, 0);

    chk("no_rd_wr_overlap", ovl_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
